// File: rtl/exp_pkg.sv
// rtl/exp_pkg.sv - shared types and constants for the Q8.8 series-evaluation controller
package exp_pkg;

    typedef enum logic [2:0] {
        IDLE,
        LOAD,
        MUL_X,
        MUL_C,
        ACC,
        DONE
    } state_t;

    localparam logic [15:0] ONE_Q88   = 16'h0100;
    localparam int          ROM_DEPTH = 8;

endpackage

// File: rtl/exp_series_ctrl.sv
// rtl/exp_series_ctrl.sv - sequencer driving the series datapath: load, multiply by x, multiply by coefficient, accumulate
module exp_series_ctrl
    import exp_pkg::*;
#(
    parameter int N_TERMS = ROM_DEPTH
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       start,
    input  logic       alt_sign,
    input  logic       less_cmp,
    output logic       busy,
    output logic       done,
    output logic       s1_rom,
    output logic       s2_x,
    output logic [7:0] s3,
    output logic       s4_in,
    output logic       ld_x,
    output logic       ld_y,
    output logic       ld_tmp,
    output logic       init_tmp,
    output logic       ld_ans,
    output logic       init_ans,
    output logic       sub
);

    localparam int            KW     = (N_TERMS > 1) ? $clog2(N_TERMS) : 1;
    localparam logic [KW-1:0] K_LAST = KW'(N_TERMS - 1);

    state_t        state_q, state_d;
    logic [KW-1:0] k_q, k_d;
    logic          alt_q, alt_d;
    logic          init_q;

    // init_* feed asynchronous sets in the datapath, so they come straight from a flop
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            k_q     <= '0;
            alt_q   <= 1'b0;
            init_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            k_q     <= k_d;
            alt_q   <= alt_d;
            init_q  <= (state_d == LOAD);
        end
    end

    always_comb begin
        state_d = state_q;
        k_d     = k_q;
        alt_d   = alt_q;
        done    = 1'b0;
        s1_rom  = 1'b0;
        s4_in   = 1'b0;
        ld_x    = 1'b0;
        ld_y    = 1'b0;
        ld_tmp  = 1'b0;
        ld_ans  = 1'b0;
        sub     = 1'b0;
        case (state_q)
            IDLE: begin
                if (start) begin
                    state_d = LOAD;
                    alt_d   = alt_sign;
                    k_d     = '0;
                end
            end
            LOAD: begin
                s4_in   = 1'b1;
                ld_x    = 1'b1;
                ld_y    = 1'b1;
                state_d = MUL_X;
            end
            MUL_X: begin
                ld_tmp  = 1'b1;
                state_d = MUL_C;
            end
            MUL_C: begin
                s1_rom  = 1'b1;
                ld_tmp  = 1'b1;
                state_d = ACC;
            end
            ACC: begin
                // even-index terms are subtracted in the alternating series
                sub = alt_q & ~k_q[0];
                if (less_cmp) begin
                    state_d = DONE;
                end else begin
                    ld_ans = 1'b1;
                    if (k_q == K_LAST) begin
                        state_d = DONE;
                    end else begin
                        k_d     = k_q + 1'b1;
                        state_d = MUL_X;
                    end
                end
            end
            DONE: begin
                done    = 1'b1;
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    assign busy     = (state_q != IDLE);
    assign s2_x     = 1'b0;
    assign s3       = {{(8 - KW){1'b0}}, k_q};
    assign init_tmp = init_q;
    assign init_ans = init_q;

endmodule

// File: tb/tb_exp_series_ctrl.sv
// tb/tb_exp_series_ctrl.sv - randomized self-checking bench with behavioural datapath and golden series model
module tb_exp_series_ctrl;
    import exp_pkg::*;

    localparam int N = 8;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        start = 1'b0;
    logic        alt_sign = 1'b0;
    logic        less_cmp;
    logic        busy, done, s1_rom, s2_x, s4_in, ld_x, ld_y, ld_tmp;
    logic        init_tmp, ld_ans, init_ans, sub;
    logic [7:0]  s3;

    logic [15:0] x_in = 16'h0;
    logic [7:0]  y_in = 8'h0;
    logic [15:0] x_r, tmp_r, ans_r;
    logic [7:0]  y_r;
    logic [15:0] rom [N];

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    exp_series_ctrl #(.N_TERMS(N)) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .start    (start),
        .alt_sign (alt_sign),
        .less_cmp (less_cmp),
        .busy     (busy),
        .done     (done),
        .s1_rom   (s1_rom),
        .s2_x     (s2_x),
        .s3       (s3),
        .s4_in    (s4_in),
        .ld_x     (ld_x),
        .ld_y     (ld_y),
        .ld_tmp   (ld_tmp),
        .init_tmp (init_tmp),
        .ld_ans   (ld_ans),
        .init_ans (init_ans),
        .sub      (sub)
    );

    function automatic logic [15:0] q_mul(input logic [15:0] a, input logic [15:0] b);
        logic [31:0] p;
        p = 32'(a) * 32'(b);
        return p[23:8];
    endfunction

    initial begin
        for (int i = 0; i < N; i++) rom[i] = 16'(256 / (i + 1));
    end

    assign less_cmp = (tmp_r < {8'b0, y_r});

    // behavioural datapath steered only by the controller outputs
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            x_r   <= 16'h0;
            y_r   <= 8'h0;
            tmp_r <= 16'h0;
            ans_r <= 16'h0;
        end else begin
            if (init_tmp)
                tmp_r <= ONE_Q88;
            else if (ld_tmp)
                tmp_r <= q_mul(s1_rom ? rom[s3[2:0]] : x_r, s2_x ? x_r : tmp_r);
            if (init_ans)
                ans_r <= ONE_Q88;
            else if (ld_ans)
                ans_r <= sub ? ans_r - tmp_r : ans_r + tmp_r;
            if (ld_x) x_r <= s4_in ? x_in : q_mul(x_r, tmp_r);
            if (ld_y) y_r <= y_in;
        end
    end

    function automatic logic [18:0] out_vec();
        return {busy, done, s1_rom, s2_x, s3, s4_in, ld_x, ld_y, ld_tmp,
                init_tmp, ld_ans, init_ans, sub};
    endfunction

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    // series evaluated straight from its definition: term_j = x^(j+1) * prod rom[0..j]
    task automatic series_model(input logic [15:0] x, input logic [7:0] y, input bit alt,
                                output logic [15:0] ans, output int nterms, output int done_cyc);
        logic [15:0] t;
        ans      = ONE_Q88;
        t        = ONE_Q88;
        nterms   = N;
        done_cyc = 3 * N + 2;
        for (int j = 0; j < N; j++) begin
            t = q_mul(rom[j], q_mul(x, t));
            if (t < {8'b0, y}) begin
                nterms   = j;
                done_cyc = 3 * j + 5;
                break;
            end
            ans = (alt && (j % 2 == 0)) ? ans - t : ans + t;
        end
    endtask

    task automatic do_reset();
        @(posedge clk); #1;
        rst_n = 1'b0;
        start = 1'b0;
        #1;
        check_eq("reset_outs", 32'(out_vec()), 32'h0);
        @(posedge clk); #1;
        rst_n = 1'b1;
    endtask

    task automatic run(input logic [15:0] x, input logic [7:0] y, input bit alt,
                       input int p1, input int p2);
        logic [15:0] exp_ans;
        int exp_terms, exp_done, cyc, done_cyc, n_ld, n_mulc;
        bit busy_ok;
        series_model(x, y, alt, exp_ans, exp_terms, exp_done);
        @(posedge clk); #1;
        x_in = x; y_in = y; alt_sign = alt; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0; alt_sign = ~alt;
        cyc = 1; done_cyc = 0; n_ld = 0; n_mulc = 0; busy_ok = 1'b1;
        check_eq("load_strobes", 32'({ld_x, ld_y, s4_in, init_tmp, init_ans}), 32'h1f);
        while (cyc <= 100 && done_cyc == 0) begin
            start = (cyc == p1 || cyc == p2);
            if (!busy) busy_ok = 1'b0;
            if (s1_rom && ld_tmp) begin
                check_eq("s3_k", 32'(s3), 32'(n_mulc));
                n_mulc++;
            end
            if (ld_ans) begin
                check_eq("sub", 32'(sub), 32'(alt && (n_ld % 2 == 0)));
                n_ld++;
            end
            if (done) begin
                done_cyc = cyc;
                check_eq("ans", 32'(ans_r), 32'(exp_ans));
            end else begin
                @(posedge clk); #1;
                cyc++;
            end
        end
        check_eq("done_cycle", 32'(done_cyc), 32'(exp_done));
        check_eq("ld_ans_count", 32'(n_ld), 32'(exp_terms));
        check_eq("busy_contig", 32'(busy_ok), 32'h1);
        @(posedge clk); #1;
        start = 1'b0;
        check_eq("done_single", 32'({done, busy}), 32'h0);
        @(posedge clk); #1;
        check_eq("no_requeue", 32'(busy), 32'h0);
    endtask

    initial begin
        int gap, ndone;
        bit seen_done;
        #2;
        check_eq("por_outs", 32'(out_vec()), 32'h0);
        @(posedge clk); #1;
        rst_n = 1'b1;

        run(16'h0100, 8'h00, 1'b0, 0, 0);
        run(16'h0000, 8'h01, 1'b0, 0, 0);
        run(16'h0080, 8'h00, 1'b1, 0, 0);
        run(16'h0100, 8'h00, 1'b0, 4, 26);

        // reset in the middle of the k=3 coefficient multiply
        @(posedge clk); #1;
        x_in = 16'h0100; y_in = 8'h00; alt_sign = 1'b1; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        for (int c = 1; c < 12; c++) begin
            @(posedge clk); #1;
        end
        check_eq("mulc_k3", 32'({s1_rom, ld_tmp, s3}), 32'({2'b11, 8'd3}));
        rst_n = 1'b0;
        #1;
        check_eq("midrun_rst_outs", 32'(out_vec()), 32'h0);
        @(posedge clk); #1;
        rst_n = 1'b1;
        run(16'h0180, 8'h02, 1'b0, 0, 0);

        // start held high: back-to-back runs with a single IDLE cycle between
        @(posedge clk); #1;
        x_in = 16'h0100; y_in = 8'h00; alt_sign = 1'b0; start = 1'b1;
        gap = 0; ndone = 0; seen_done = 1'b0;
        for (int c = 1; c <= 60; c++) begin
            @(posedge clk); #1;
            if (done) begin
                ndone++;
                seen_done = 1'b1;
                gap = 0;
            end else if (!busy) begin
                gap++;
            end else if (seen_done) begin
                check_eq("idle_gap", 32'(gap), 32'h1);
                check_eq("reload", 32'(ld_x), 32'h1);
                seen_done = 1'b0;
            end
        end
        start = 1'b0;
        check_eq("held_runs", 32'(ndone), 32'h2);
        do_reset();

        for (int i = 0; i < 12; i++) begin
            run(16'($urandom_range(0, 16'h01ff)), 8'($urandom_range(0, 8'h30)),
                1'($urandom_range(0, 1)), 0, 0);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
